// File: rtl/inst_queue_mw_pkg.sv
// Shared system definitions: instruction-queue entry layout, the invalid-NOOP value
// and the default queue geometry.
package sys_defs;
    localparam int IQ_SIZE     = 16;
    localparam int FETCH_WIDTH = 2;
    localparam int DISP_WIDTH  = 2;
    localparam bit DEBUG       = 1'b0;

    localparam logic [31:0] NOOP_INST = 32'h47ff041f;

    typedef struct packed {
        logic        is_br;
        logic        pred_taken;
        logic [31:0] pred_target;
    } BR_INFO;

    typedef struct packed {
        logic        valid_inst;
        logic [31:0] npc;
        logic [31:0] ir;
        BR_INFO      branch_inst;
    } INST_Q;

    localparam INST_Q INST_INVALID = '{valid_inst: 1'b0, npc: 32'h0, ir: NOOP_INST, branch_inst: '0};

    function automatic int min2(input int a, input int b);
        return (a < b) ? a : b;
    endfunction
endpackage

// File: rtl/inst_queue_mw_if.sv
// Fetch/dispatch bundle between the front end and the instruction queue.
interface inst_queue_mw_if
    import sys_defs::*;
#(
    parameter int DEPTH   = IQ_SIZE,
    parameter int FETCH_W = FETCH_WIDTH,
    parameter int DISP_W  = DISP_WIDTH
);
    localparam int CW  = $clog2(DEPTH) + 1;
    localparam int PW  = $clog2(DEPTH);
    localparam int FCW = $clog2(FETCH_W + 1);
    localparam int DCW = $clog2(DISP_W + 1);

    logic [FCW-1:0]          fetch_count;
    INST_Q [FETCH_W-1:0]     if_inst_in;
    logic [DCW-1:0]          dispatch_count;
    logic                    branch_incorrect;
    logic                    fetch_accept;
    INST_Q [DISP_W-1:0]      if_inst_out;
    logic [CW-1:0]           inst_queue_entry;
    logic                    inst_queue_full_out;
    logic [CW-1:0]           free_slots;
    INST_Q [DEPTH-1:0]       inst_queue_out;
    logic [PW-1:0]           head;
    logic [PW-1:0]           tail;

    modport master (
        output fetch_count, if_inst_in, dispatch_count, branch_incorrect,
        input  fetch_accept, if_inst_out, inst_queue_entry, inst_queue_full_out,
               free_slots, inst_queue_out, head, tail
    );

    modport slave (
        input  fetch_count, if_inst_in, dispatch_count, branch_incorrect,
        output fetch_accept, if_inst_out, inst_queue_entry, inst_queue_full_out,
               free_slots, inst_queue_out, head, tail
    );
endinterface

// File: rtl/inst_queue_mw_sel.sv
// Oldest-first dispatch selection: queue entries from head, then accepted fetch
// lanes bypassed in the same cycle.
module inst_queue_mw_sel
    import sys_defs::*;
#(
    parameter int DEPTH   = IQ_SIZE,
    parameter int FETCH_W = FETCH_WIDTH,
    parameter int DISP_W  = DISP_WIDTH,
    localparam int CW  = $clog2(DEPTH) + 1,
    localparam int FCW = $clog2(FETCH_W + 1),
    localparam int DCW = $clog2(DISP_W + 1)
) (
    input  INST_Q [DISP_W-1:0]  i_win,
    input  logic  [CW-1:0]      i_occ,
    input  INST_Q [FETCH_W-1:0] i_fetch,
    input  logic  [FCW-1:0]     i_fetch_n,
    input  logic  [DCW-1:0]     i_disp_n,
    output INST_Q [DISP_W-1:0]  o_sel,
    output logic  [DCW-1:0]     o_nq,
    output logic  [DCW-1:0]     o_nf
);
    int w_n, w_nq;

    always_comb begin
        w_n  = min2(int'(i_disp_n), int'(i_occ) + int'(i_fetch_n));
        w_nq = min2(w_n, int'(i_occ));
        o_nq = DCW'(w_nq);
        o_nf = DCW'(w_n - w_nq);
        for (int i = 0; i < DISP_W; i++) begin
            o_sel[i] = INST_INVALID;
            if (i < w_nq) begin
                o_sel[i] = i_win[i];
            end else if (i < w_n) begin
                for (int j = 0; j < FETCH_W; j++)
                    if (i - w_nq == j) o_sel[i] = i_fetch[j];
            end
        end
    end
endmodule

// File: rtl/inst_queue_mw.sv
// Multi-wide circular instruction queue: all-or-nothing fetch write, oldest-first
// dispatch with fetch bypass, flush on branch mispredict.
module inst_queue_mw
    import sys_defs::*;
#(
    parameter int DEPTH   = IQ_SIZE,
    parameter int FETCH_W = FETCH_WIDTH,
    parameter int DISP_W  = DISP_WIDTH
) (
    input  logic            clock,
    input  logic            reset,
    inst_queue_mw_if.slave  bus
);
    localparam int CW  = $clog2(DEPTH) + 1;
    localparam int PW  = $clog2(DEPTH);
    localparam int FCW = $clog2(FETCH_W + 1);
    localparam int DCW = $clog2(DISP_W + 1);

    INST_Q [DEPTH-1:0]  r_q, w_q_nxt;
    INST_Q [DISP_W-1:0] r_out, w_win, w_sel;
    logic  [PW-1:0]     r_head, r_tail;
    logic  [CW-1:0]     r_occ, r_free, w_occ_nxt;
    logic               r_full, w_acc;
    logic  [FCW-1:0]    w_fn, w_nw;
    logic  [DCW-1:0]    w_nq, w_nf;

    // Room is judged on the registered free count only; dispatch this cycle does not help.
    assign w_acc = !bus.branch_incorrect && (CW'(bus.fetch_count) <= r_free);
    assign w_fn  = w_acc ? bus.fetch_count : '0;
    assign w_nw  = w_fn - FCW'(w_nf);
    assign w_occ_nxt = r_occ + CW'(w_fn) - CW'(w_nq) - CW'(w_nf);

    always_comb begin
        for (int i = 0; i < DISP_W; i++) w_win[i] = r_q[r_head + PW'(i)];
    end

    inst_queue_mw_sel #(.DEPTH(DEPTH), .FETCH_W(FETCH_W), .DISP_W(DISP_W)) u_sel (
        .i_win     (w_win),
        .i_occ     (r_occ),
        .i_fetch   (bus.if_inst_in),
        .i_fetch_n (w_fn),
        .i_disp_n  (bus.dispatch_count),
        .o_sel     (w_sel),
        .o_nq      (w_nq),
        .o_nf      (w_nf)
    );

    // Vacated head slots and newly written tail slots never overlap since occ+writes <= DEPTH.
    always_comb begin
        w_q_nxt = r_q;
        for (int j = 0; j < DISP_W; j++)
            if (DCW'(j) < w_nq) w_q_nxt[r_head + PW'(j)] = INST_INVALID;
        for (int j = 0; j < FETCH_W; j++)
            if (FCW'(j) < w_nw)
                for (int m = 0; m < FETCH_W; m++)
                    if (FCW'(m) == FCW'(j) + FCW'(w_nf)) w_q_nxt[r_tail + PW'(j)] = bus.if_inst_in[m];
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_q    <= {DEPTH{INST_INVALID}};
            r_out  <= {DISP_W{INST_INVALID}};
            r_head <= '0;
            r_tail <= '0;
            r_occ  <= '0;
            r_full <= 1'b0;
            r_free <= CW'(DEPTH);
        end else if (bus.branch_incorrect) begin
            r_q    <= {DEPTH{INST_INVALID}};
            r_out  <= {DISP_W{INST_INVALID}};
            r_head <= '0;
            r_tail <= '0;
            r_occ  <= '0;
            r_full <= 1'b0;
            r_free <= CW'(DEPTH);
        end else begin
            r_q    <= w_q_nxt;
            r_out  <= w_sel;
            r_head <= r_head + PW'(w_nq);
            r_tail <= r_tail + PW'(w_nw);
            r_occ  <= w_occ_nxt;
            r_full <= (w_occ_nxt == CW'(DEPTH));
            r_free <= CW'(DEPTH) - w_occ_nxt;
        end
    end

    assign bus.fetch_accept        = w_acc;
    assign bus.if_inst_out         = r_out;
    assign bus.inst_queue_entry    = r_occ;
    assign bus.inst_queue_full_out = r_full;
    assign bus.free_slots          = r_free;

    generate
        if (DEBUG) begin : g_dbg
            for (genvar i = 0; i < DEPTH; i++) begin : g_slot
                assign bus.inst_queue_out[i] = r_q[r_head + PW'(i)];
            end
            assign bus.head = r_head;
            assign bus.tail = r_tail;
            always @(posedge clock) begin
                if (reset) begin
                    assert (int'(bus.fetch_count) <= FETCH_W);
                    assert (int'(bus.dispatch_count) <= DISP_W);
                end
            end
        end else begin : g_nodbg
            assign bus.inst_queue_out = '0;
            assign bus.head           = '0;
            assign bus.tail           = '0;
        end
    endgenerate
endmodule

// File: tb/tb_inst_queue_mw.sv
// Randomised and directed bench for inst_queue_mw against a queue-based reference model.
module tb_inst_queue_mw;
    import sys_defs::*;

    localparam int DEPTH = 8;
    localparam int FW    = 2;
    localparam int DW    = 2;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    inst_queue_mw_if #(.DEPTH(DEPTH), .FETCH_W(FW), .DISP_W(DW)) bus();
    inst_queue_mw #(.DEPTH(DEPTH), .FETCH_W(FW), .DISP_W(DW)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    INST_Q       mq[$];
    INST_Q       exp_out [DW];
    int          n_vec = 0;
    int          n_err = 0;
    int unsigned npc_ctr = 4;
    logic        last_acc;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic INST_Q mk_inst(input int unsigned npc);
        INST_Q r;
        r.valid_inst              = 1'b1;
        r.npc                     = npc;
        r.ir                      = $urandom;
        r.branch_inst.is_br       = 1'($urandom);
        r.branch_inst.pred_taken  = 1'($urandom);
        r.branch_inst.pred_target = $urandom;
        return r;
    endfunction

    task automatic model_clear();
        mq.delete();
        for (int i = 0; i < DW; i++) exp_out[i] = INST_INVALID;
    endtask

    task automatic check_outputs();
        for (int i = 0; i < DW; i++)
            chk($sformatf("if_inst_out[%0d]", i), 128'(bus.if_inst_out[i]), 128'(exp_out[i]));
        chk("inst_queue_entry", 128'(bus.inst_queue_entry), 128'(mq.size()));
        chk("inst_queue_full_out", 128'(bus.inst_queue_full_out), 128'(mq.size() == DEPTH));
        chk("free_slots", 128'(bus.free_slots), 128'(DEPTH - mq.size()));
    endtask

    // One clock: check registered outputs, drive a bundle, check accept, advance the model.
    task automatic cycle(input int fc, input int dc, input bit bi);
        INST_Q lanes [FW];
        INST_Q all[$];
        bit    acc;
        int    n;
        check_outputs();
        for (int i = 0; i < FW; i++) begin
            if (i < fc) begin
                lanes[i] = mk_inst(npc_ctr);
                npc_ctr += 4;
            end else begin
                lanes[i] = mk_inst($urandom);
                lanes[i].valid_inst = 1'($urandom);
            end
            bus.if_inst_in[i] = lanes[i];
        end
        bus.fetch_count      = 2'(fc);
        bus.dispatch_count   = 2'(dc);
        bus.branch_incorrect = bi;
        #1;
        acc = !bi && (fc <= DEPTH - mq.size());
        chk("fetch_accept", 128'(bus.fetch_accept), 128'(acc));
        last_acc = bus.fetch_accept;
        if (bi) begin
            model_clear();
        end else begin
            all = mq;
            if (acc) for (int i = 0; i < fc; i++) all.push_back(lanes[i]);
            n = (dc < all.size()) ? dc : all.size();
            for (int i = 0; i < DW; i++) begin
                if (i < n) exp_out[i] = all.pop_front();
                else       exp_out[i] = INST_INVALID;
            end
            mq = all;
        end
        @(negedge clock);
    endtask

    initial begin
        int fc, dc;
        bit bi;
        bus.fetch_count      = '0;
        bus.dispatch_count   = '0;
        bus.branch_incorrect = 1'b0;
        bus.if_inst_in       = '0;
        model_clear();

        repeat (2) @(negedge clock);
        reset = 1'b1;
        #1;
        chk("rst entry", 128'(bus.inst_queue_entry), 128'(0));
        chk("rst full", 128'(bus.inst_queue_full_out), 128'(0));
        chk("rst free", 128'(bus.free_slots), 128'(8));
        chk("rst lane0 valid", 128'(bus.if_inst_out[0].valid_inst), 128'(0));
        chk("rst lane1 npc", 128'(bus.if_inst_out[1].npc), 128'(0));
        chk("rst lane1 ir", 128'(bus.if_inst_out[1].ir), 128'(32'h47ff041f));
        @(negedge clock);

        // Bypass from an empty queue
        npc_ctr = 4;
        cycle(2, 2, 0);
        chk("bypass lane0 npc", 128'(bus.if_inst_out[0].npc), 128'('h4));
        chk("bypass lane1 npc", 128'(bus.if_inst_out[1].npc), 128'('h8));
        chk("bypass entry", 128'(bus.inst_queue_entry), 128'(0));

        // Fill, then try to overfill
        repeat (4) cycle(2, 0, 0);
        chk("fill entry", 128'(bus.inst_queue_entry), 128'(8));
        chk("fill full", 128'(bus.inst_queue_full_out), 128'(1));
        cycle(1, 0, 0);
        chk("overfill accept", 128'(last_acc), 128'(0));
        chk("overfill entry", 128'(bus.inst_queue_entry), 128'(8));

        // Full queue: dispatch does not make room the same cycle; then drain across the wrap
        cycle(1, 1, 0);
        chk("full disp accept", 128'(last_acc), 128'(0));
        chk("full disp lane0", 128'(bus.if_inst_out[0].npc), 128'('hc));
        chk("full disp entry", 128'(bus.inst_queue_entry), 128'(7));
        repeat (4) cycle(0, 2, 0);
        chk("drain entry", 128'(bus.inst_queue_entry), 128'(0));
        chk("drain last lane0", 128'(bus.if_inst_out[0].npc), 128'('h28));
        chk("drain last lane1 valid", 128'(bus.if_inst_out[1].valid_inst), 128'(0));

        // Entry=3 with simultaneous fetch and dispatch
        cycle(2, 0, 0);
        cycle(1, 0, 0);
        chk("three entry", 128'(bus.inst_queue_entry), 128'(3));
        npc_ctr = 'hff0;
        cycle(2, 2, 0);
        chk("mix lane0", 128'(bus.if_inst_out[0].npc), 128'('h34));
        chk("mix lane1", 128'(bus.if_inst_out[1].npc), 128'('h38));
        chk("mix entry", 128'(bus.inst_queue_entry), 128'(3));
        cycle(0, 2, 0);
        chk("tail order lane0", 128'(bus.if_inst_out[0].npc), 128'('h3c));
        chk("tail order lane1", 128'(bus.if_inst_out[1].npc), 128'('hff0));

        // Flush with fetch and dispatch pending
        cycle(2, 0, 0);
        cycle(2, 0, 0);
        chk("pre-flush entry", 128'(bus.inst_queue_entry), 128'(5));
        cycle(2, 2, 1);
        chk("flush entry", 128'(bus.inst_queue_entry), 128'(0));
        chk("flush free", 128'(bus.free_slots), 128'(8));
        chk("flush lane0 valid", 128'(bus.if_inst_out[0].valid_inst), 128'(0));
        chk("flush lane1 ir", 128'(bus.if_inst_out[1].ir), 128'(32'h47ff041f));

        // Random traffic, alternating fill-heavy and drain-heavy phases, with a mid-run reset
        for (int it = 0; it < 400; it++) begin
            if (it == 150) begin
                #2 reset = 1'b0;
                #1;
                chk("midrst entry", 128'(bus.inst_queue_entry), 128'(0));
                chk("midrst full", 128'(bus.inst_queue_full_out), 128'(0));
                chk("midrst free", 128'(bus.free_slots), 128'(8));
                chk("midrst lane0 valid", 128'(bus.if_inst_out[0].valid_inst), 128'(0));
                chk("midrst lane1 ir", 128'(bus.if_inst_out[1].ir), 128'(32'h47ff041f));
                model_clear();
                @(negedge clock);
                reset = 1'b1;
            end else begin
                if (((it / 40) % 2) == 0) begin
                    fc = ($urandom_range(0, 9) < 7) ? 2 : int'($urandom_range(0, 1));
                    dc = int'($urandom_range(0, 2));
                end else begin
                    fc = int'($urandom_range(0, 2));
                    dc = ($urandom_range(0, 9) < 7) ? 2 : int'($urandom_range(0, 1));
                end
                bi = ($urandom_range(0, 39) == 0);
                cycle(fc, dc, bi);
            end
        end
        check_outputs();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/inst_queue_mw.md
INST_QUEUE_MW -- requirements
Module: inst_queue_mw

Interface
REQ-001 SHALL have parameter DEPTH, default 16, queue entries (power of two, >= 2*FETCH_W).
REQ-002 SHALL have parameter FETCH_W, default 2, instructions written per cycle.
REQ-003 SHALL have parameter DISP_W, default 2, instructions read per cycle.
REQ-004 SHALL have port clock  in  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port fetch_count  in  clog2(FETCH_W+1)  number of valid lanes in if_inst_in, packed from lane 0.
REQ-007 SHALL have port if_inst_in  in  FETCH_W x INST_Q  fetched bundle, lane 0 oldest.
REQ-008 SHALL have port dispatch_count  in  clog2(DISP_W+1)  instructions dispatch accepts this cycle.
REQ-009 SHALL have port branch_incorrect  in  1  flush request.
REQ-010 SHALL have port fetch_accept  out  1  combinational; bundle written this cycle.
REQ-011 SHALL have port if_inst_out  out  DISP_W x INST_Q  registered dispatched instructions, lane 0 oldest.
REQ-012 SHALL have port inst_queue_entry  out  clog2(DEPTH)+1  registered occupancy.
REQ-013 SHALL have port inst_queue_full_out  out  1  registered; occupancy == DEPTH.
REQ-014 SHALL have port free_slots  out  clog2(DEPTH)+1  registered; DEPTH - occupancy.
REQ-015 SHALL have ports inst_queue_out (DEPTH x INST_Q, slot order from head) and head/tail pointers, present only under DEBUG.

Function
REQ-016 SHALL store entries in a circular buffer; head/tail pointers wrap modulo DEPTH.
REQ-017 SHALL assert fetch_accept iff branch_incorrect==0 and fetch_count <= free_slots (registered value; same-cycle dispatch does not create room); acceptance is all-or-nothing.
REQ-018 SHALL select n = min(dispatch_count, occupancy + accepted_fetch) instructions, oldest first: queue entries from head, then accepted fetch lanes from lane 0 (same-cycle bypass).
REQ-019 SHALL present the n selected instructions on if_inst_out lanes 0..n-1 one cycle later; lanes >= n SHALL read valid_inst=0, npc=0, ir=NOOP_INST, branch_inst all zero.
REQ-020 SHALL write accepted fetch lanes not consumed by bypass at tail, in lane order; tail advances by that number.
REQ-021 SHALL update occupancy = occupancy + accepted_fetch - n; head advances by dispatched queue entries; vacated slots cleared to the invalid-NOOP value.
REQ-022 SHALL, on branch_incorrect==1, ignore fetch and dispatch that cycle; next cycle occupancy=0, head=tail=0, all entries and if_inst_out lanes invalid-NOOP.
REQ-023 SHALL, with dispatch_count==0 and fetch rejected or zero, hold all state; if_inst_out becomes invalid-NOOP.
REQ-024 SHALL treat dispatch_count > available as dispatching only available; empty queue with no fetch dispatches nothing.
REQ-025 SHALL treat fetch_count > FETCH_W or dispatch_count > DISP_W as illegal (assertion in DEBUG).

Reset
REQ-026 SHALL, while reset==0, asynchronously force occupancy=0, head=tail=0, inst_queue_full_out=0, free_slots=DEPTH, all entries and if_inst_out to invalid-NOOP.
REQ-027 SHALL discard any in-flight fetch/dispatch when reset asserts mid-operation; first update occurs on the first rising edge after reset==1.

Structure
REQ-028 SHALL take INST_Q, NOOP_INST, DEBUG from the shared sys_defs package; DEPTH/FETCH_W/DISP_W defaults SHALL be package constants IQ_SIZE, FETCH_WIDTH, DISP_WIDTH.
REQ-029 SHALL place oldest-first selection across queue head and fetch bypass in one combinational sub-module inst_queue_mw_sel.

Verification (DEPTH=8, FETCH_W=2, DISP_W=2)
REQ-030 Reset low two cycles, then high -> entry=0, full=0, free_slots=8, if_inst_out all valid=0/npc=0/NOOP.
REQ-031 Empty queue, fetch_count=2 (npc 0x4,0x8), dispatch_count=2 -> next cycle if_inst_out lanes 0/1 npc 0x4/0x8, entry=0.
REQ-032 Four cycles fetch_count=2, dispatch_count=0 -> entry=8, full=1; fifth fetch_count=1 -> fetch_accept=0, entry stays 8.
REQ-033 Full queue, dispatch_count=1 with fetch_count=1 -> fetch rejected, if_inst_out lane0 = oldest, entry=7; then dispatch_count=2 for 4 cycles -> head wraps, order preserved, entry=0 after ceil(7/2)=4 cycles.
REQ-034 Entry=3, fetch_count=2 (npc 0xff0,0xff4), dispatch_count=2 -> lanes = two oldest queued, entry=3, new entries at tail in order.
REQ-035 Entry=5, branch_incorrect=1 with fetch_count=2, dispatch_count=2 -> next cycle entry=0, free_slots=8, if_inst_out invalid; reset pulsed mid-run -> same reset state immediately.
